// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with a valid/ready handshake. It carries a control
// bundle and a data bundle between two stages, supports a synchronous flush,
// an optional second (skid) entry, and counts stalled output cycles.
//
//  state | meaning
//  EMPTY | no valid entry held, so out_ctrl reads as a NOP
//  ONE   | main register holds the head beat
//  TWO   | main holds the head beat and skid holds the next one (SKID=1 only)
module pipe_stage_buf #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                main_valid, skid_valid;
  logic                in_hs, out_hs;
  logic                load_main_in, load_main_skid, load_skid;
  logic [CTRL_W-1:0]   main_ctrl, skid_ctrl;
  logic [DATA_W-1:0]   main_data, skid_data;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == TWO);

  // With a skid entry, in_ready depends only on registered state, so it
  // breaks the combinational ready path. Without one, the single entry may
  // be refilled in the same cycle that the downstream consumes it.
  if (SKID != 0) begin : g_ready_skid
    assign in_ready = !skid_valid && !flush && !rst;
  end else begin : g_ready_single
    assign in_ready = (!main_valid || out_ready) && !flush && !rst;
  end

  assign in_hs  = in_valid && in_ready;
  assign out_hs = main_valid && out_ready;

  // Next-state and register load selects. A flush overrides everything.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_hs) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_hs && out_hs) begin
          load_main_in = 1'b1;
        end else if (in_hs) begin
          // Only reachable with SKID=1. The single-entry ready term
          // requires out_ready whenever main is valid.
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (out_hs) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_hs) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Main entry. It keeps its contents when drained, so out_data holds the
  // last beat until a flush or reset zeroes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (load_main_in) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end else if (load_main_skid) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
    end
  end

  // Skid entry. It catches the beat that was in flight when the stall began.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (load_skid) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

  // Saturating stall counter. Only reset clears it; a flush does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Occupancy is decoded from the registered state.
  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf. It drives a skid instance (SKID=1, CNT_W=4) and a
// single-entry instance (SKID=0) with the same stimulus. Each instance is
// compared against its own FIFO reference model, and directed vectors cover
// the corner cases.
module tb_pipe_stage_buf;

  localparam int CW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          rdy_s, ov_s, rdy_n, ov_n;
  logic [CW-1:0] oc_s, oc_n;
  logic [DW-1:0] od_s, od_n;
  logic [1:0]    occ_s, occ_n;
  logic [3:0]    sc_s;
  logic [15:0]   sc_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_s),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_s), .out_ready(out_ready),
    .out_ctrl(oc_s), .out_data(od_s), .occupancy(occ_s), .stall_cnt(sc_s));

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_single (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_n),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_n), .out_ready(out_ready),
    .out_ctrl(oc_n), .out_data(od_n), .occupancy(occ_n), .stall_cnt(sc_n));

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  // Reference model: each instance is a FIFO of beats with a capacity limit.
  beat_t       mbuf[2][2];
  int          mcnt[2];
  logic [31:0] mlast[2];
  int          msc[2];
  int          mscmax[2];

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h expected=%h", nm, i, act, exp);
    end
  endtask

  task automatic reset_models();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0;
      mlast[i] = '0;
      msc[i] = 0;
    end
    mscmax[0] = 15;
    mscmax[1] = 65535;
  endtask

  // Drive inputs just after the falling edge; outputs settle by #1.
  task automatic drive(input logic f, input logic iv, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input logic ordy);
    @(negedge clk);
    flush = f;
    in_valid = iv;
    in_ctrl = c;
    in_data = d;
    out_ready = ordy;
    #1;
  endtask

  // Compare both instances to the model, then advance the model across the edge.
  task automatic model_step();
    logic        a_rdy, a_ov;
    logic [31:0] a_oc, a_od, a_occ, a_sc;
    logic        e_rdy, e_ov, ihs, ohs;
    logic [31:0] e_oc, e_od;
    beat_t       nb;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        a_rdy = rdy_s; a_ov = ov_s; a_oc = 32'(oc_s); a_od = od_s; a_occ = 32'(occ_s); a_sc = 32'(sc_s);
        e_rdy = (mcnt[i] < 2) && !flush;
      end else begin
        a_rdy = rdy_n; a_ov = ov_n; a_oc = 32'(oc_n); a_od = od_n; a_occ = 32'(occ_n); a_sc = 32'(sc_n);
        e_rdy = ((mcnt[i] == 0) || out_ready) && !flush;
      end
      e_ov = (mcnt[i] > 0);
      e_oc = e_ov ? 32'(mbuf[i][0].c) : 32'd0;
      e_od = e_ov ? mbuf[i][0].d : mlast[i];
      chk("m_in_ready", i, 32'(a_rdy), 32'(e_rdy));
      chk("m_out_valid", i, 32'(a_ov), 32'(e_ov));
      chk("m_out_ctrl", i, a_oc, e_oc);
      chk("m_out_data", i, a_od, e_od);
      chk("m_occupancy", i, a_occ, 32'(mcnt[i]));
      chk("m_stall_cnt", i, a_sc, 32'(msc[i]));
      ihs = in_valid && e_rdy;
      ohs = e_ov && out_ready;
      if (e_ov && !out_ready && msc[i] < mscmax[i]) msc[i]++;
      if (flush) begin
        mcnt[i] = 0;
        mlast[i] = '0;
      end else begin
        if (ohs) begin
          mlast[i] = mbuf[i][0].d;
          mbuf[i][0] = mbuf[i][1];
          mcnt[i]--;
        end
        if (ihs) begin
          nb.c = in_ctrl;
          nb.d = in_data;
          mbuf[i][mcnt[i]] = nb;
          mcnt[i]++;
        end
      end
    end
  endtask

  typedef struct {
    logic          iv;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_rdy;
    logic          e_ov;
    logic [CW-1:0] e_oc;
    logic [DW-1:0] e_od;
    logic [1:0]    e_occ;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // Skid instance: A and B fill both entries, C is refused, then the stage drains.
    tbl[0] = '{1'b1, 16'h0001, 32'h0000_000A, 1'b0, 1'b1, 1'b0, 16'h0000, 32'h0, 2'd0};
    tbl[1] = '{1'b1, 16'h0002, 32'h0000_000B, 1'b0, 1'b1, 1'b1, 16'h0001, 32'hA, 2'd1};
    tbl[2] = '{1'b1, 16'h0003, 32'h0000_000C, 1'b0, 1'b0, 1'b1, 16'h0001, 32'hA, 2'd2};
    tbl[3] = '{1'b0, 16'h0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 16'h0001, 32'hA, 2'd2};
    tbl[4] = '{1'b0, 16'h0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 16'h0002, 32'hB, 2'd1};
    tbl[5] = '{1'b0, 16'h0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 16'h0000, 32'hB, 2'd0};

    reset_models();
    #3;
    chk("rst_out_valid", 0, 32'(ov_s), 32'd0);
    chk("rst_in_ready", 0, 32'(rdy_s), 32'd0);
    chk("rst_in_ready", 1, 32'(rdy_n), 32'd0);
    chk("rst_out_data", 0, od_s, 32'd0);
    chk("rst_occupancy", 0, 32'(occ_s), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      drive(1'b0, tbl[k].iv, tbl[k].c, tbl[k].d, tbl[k].ordy);
      chk("tbl_in_ready", k, 32'(rdy_s), 32'(tbl[k].e_rdy));
      chk("tbl_out_valid", k, 32'(ov_s), 32'(tbl[k].e_ov));
      chk("tbl_out_ctrl", k, 32'(oc_s), 32'(tbl[k].e_oc));
      chk("tbl_out_data", k, od_s, tbl[k].e_od);
      chk("tbl_occupancy", k, 32'(occ_s), 32'(tbl[k].e_occ));
      model_step();
    end

    // Streaming at one beat per cycle.
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 1'b1, CW'(k), DW'(k), 1'b1);
      if (k > 1) begin
        chk("stream_data", k, od_s, 32'(k - 1));
        chk("stream_occ", k, 32'(occ_s), 32'd1);
        chk("stream_data", k, od_n, 32'(k - 1));
      end
      model_step();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    chk("stream_last", 0, od_s, 32'd10);
    model_step();

    // Flush with two entries held while C is offered.
    drive(1'b0, 1'b1, 16'h00A1, 32'hAAAA_0001, 1'b0); model_step();
    drive(1'b0, 1'b1, 16'h00B2, 32'hBBBB_0002, 1'b0); model_step();
    drive(1'b1, 1'b1, 16'h00C3, 32'hCCCC_0003, 1'b0);
    chk("flush_in_ready", 0, 32'(rdy_s), 32'd0);
    chk("flush_pre_occ", 0, 32'(occ_s), 32'd2);
    model_step();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    chk("flush_out_valid", 0, 32'(ov_s), 32'd0);
    chk("flush_out_ctrl", 0, 32'(oc_s), 32'd0);
    chk("flush_out_data", 0, od_s, 32'd0);
    chk("flush_occ", 0, 32'(occ_s), 32'd0);
    model_step();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    chk("flush_no_c", 0, 32'(ov_s), 32'd0);
    model_step();

    // Stall counter saturation, which a flush must not clear.
    drive(1'b0, 1'b1, 16'h00D4, 32'hDDDD_0004, 1'b0); model_step();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0); model_step();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("stall_sat", 0, 32'(sc_s), 32'd15);
    model_step();
    drive(1'b1, 1'b0, '0, '0, 1'b0); model_step();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("stall_after_flush", 0, 32'(sc_s), 32'd15);
    chk("stall_flush_valid", 0, 32'(ov_s), 32'd0);
    model_step();

    // Single-entry instance: in_ready follows out_ready and refills without a bubble.
    drive(1'b0, 1'b1, 16'h0011, 32'h1111_0000, 1'b0); model_step();
    drive(1'b0, 1'b1, 16'h0022, 32'h2222_0000, 1'b0);
    chk("single_rdy_lo", 1, 32'(rdy_n), 32'd0);
    chk("single_hold", 1, od_n, 32'h1111_0000);
    model_step();
    drive(1'b0, 1'b1, 16'h0022, 32'h2222_0000, 1'b1);
    chk("single_rdy_hi", 1, 32'(rdy_n), 32'd1);
    model_step();
    drive(1'b0, 1'b1, 16'h0033, 32'h3333_0000, 1'b0);
    chk("single_no_bubble", 1, 32'(ov_n), 32'd1);
    chk("single_replaced", 1, od_n, 32'h2222_0000);
    chk("single_rdy_lo2", 1, 32'(rdy_n), 32'd0);
    model_step();
    drive(1'b1, 1'b0, '0, '0, 1'b1); model_step();

    // Asynchronous reset with the skid instance full.
    drive(1'b0, 1'b1, 16'h00E5, 32'hEEEE_0005, 1'b0); model_step();
    drive(1'b0, 1'b1, 16'h00F6, 32'hFFFF_0006, 1'b0); model_step();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("pre_rst_occ", 0, 32'(occ_s), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 0, 32'(ov_s), 32'd0);
    chk("arst_out_ctrl", 0, 32'(oc_s), 32'd0);
    chk("arst_out_data", 0, od_s, 32'd0);
    chk("arst_occ", 0, 32'(occ_s), 32'd0);
    chk("arst_stall", 0, 32'(sc_s), 32'd0);
    chk("arst_in_ready", 0, 32'(rdy_s), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_models();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    chk("post_rst_in_ready", 0, 32'(rdy_s), 32'd1);
    chk("post_rst_stall", 0, 32'(sc_s), 32'd0);
    model_step();

    // Randomized traffic against the models.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 19) == 0), 1'($urandom), CW'($urandom), DW'($urandom),
            ($urandom_range(0, 3) != 0));
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
